// File: rtl/ifetch.sv
// ifetch - instruction fetch unit with a 2-entry prefetch FIFO.
//
// Issues one read at a time to instruction memory. Each returned word is
// queued together with its word address. The consumer reads the head entry
// and pops it with ir_cmd. A redirect (pc_cmd) flushes the queue and
// restarts fetching at pc_datain.
//
// Ports
//   clock        in   rising-edge clock
//   reset_       in   synchronous active-low reset
//   mem_req      out  memory read request (held until mem_ack)
//   mem_addr     out  [11:0] word address of the request
//   mem_ack      in   read data valid / request accepted this cycle
//   mem_rdata    in   [31:0] read data, valid with mem_ack
//   pc_cmd       in   redirect the fetch stream
//   pc_datain    in   [11:0] redirect target
//   ir_cmd       in   consumer takes the head instruction
//   inst_valid   out  head instruction available
//   op, cc       out  [3:0] head[31:28], head[27:24]
//   s_a, de_a    out  [11:0] head[23:12], head[11:0]
//   inst_pc      out  [11:0] address of the head instruction
//   pc_dataout   out  [11:0] next fetch address
//   perf_fetch   out  [15:0] saturating count of pushes       (IFETCH_PERF_EN)
//   perf_drop    out  [15:0] saturating count of dropped acks (IFETCH_PERF_EN)
//
// Build option
//   IFETCH_PERF_EN  when defined, adds the perf_fetch/perf_drop counters.
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | no request outstanding; waiting for FIFO space
// REQ   | request outstanding; its data will be queued
// DROP  | request outstanding after a redirect; its data will be discarded

module ifetch (
  input  logic        clock,
  input  logic        reset_,
  output logic        mem_req,
  output logic [11:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  input  logic        pc_cmd,
  input  logic [11:0] pc_datain,
  input  logic        ir_cmd,
  output logic        inst_valid,
  output logic [3:0]  op,
  output logic [3:0]  cc,
  output logic [11:0] s_a,
  output logic [11:0] de_a,
  output logic [11:0] inst_pc,
`ifdef IFETCH_PERF_EN
  output logic [15:0] perf_fetch,
  output logic [15:0] perf_drop,
`endif
  output logic [11:0] pc_dataout
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DROP = 2'd2
  } state_t;

  state_t      state;
  logic [1:0]  count;
  logic [31:0] head_data;
  logic [11:0] head_addr;
  logic [31:0] tail_data;
  logic [11:0] tail_addr;

  logic        pop;
  logic        push;
  logic        drop_ack;
  logic [1:0]  count_after;
  logic [11:0] pc_next;

  // A redirect kills both the consumer's pop and the returning data.
  assign pop      = ir_cmd & inst_valid & ~pc_cmd;
  assign push     = (state == S_REQ) & mem_ack & ~pc_cmd;
  assign drop_ack = mem_ack & ((state == S_DROP) | ((state == S_REQ) & pc_cmd));
  assign pc_next  = pc_dataout + 12'd1;

  always_comb begin
    count_after = count;
    if (push && !pop)
      count_after = count + 2'd1;
    else if (pop && !push)
      count_after = count - 2'd1;
  end

  // Head fields are slices of the head register, never of mem_rdata.
  assign op      = head_data[31:28];
  assign cc      = head_data[27:24];
  assign s_a     = head_data[23:12];
  assign de_a    = head_data[11:0];
  assign inst_pc = head_addr;

  always_ff @(posedge clock) begin
    if (!reset_) begin
      state      <= S_IDLE;
      count      <= 2'd0;
      inst_valid <= 1'b0;
      head_data  <= 32'd0;
      head_addr  <= 12'd0;
      tail_data  <= 32'd0;
      tail_addr  <= 12'd0;
      mem_req    <= 1'b0;
      mem_addr   <= 12'd0;
      pc_dataout <= 12'd0;
    end else begin
      // FIFO storage
      if (pc_cmd) begin
        count      <= 2'd0;
        inst_valid <= 1'b0;
      end else begin
        if (push) begin
          if (pop) begin
            if (count == 2'd2) begin
              head_data <= tail_data;
              head_addr <= tail_addr;
              tail_data <= mem_rdata;
              tail_addr <= mem_addr;
            end else begin
              head_data <= mem_rdata;
              head_addr <= mem_addr;
            end
          end else if (count == 2'd0) begin
            head_data <= mem_rdata;
            head_addr <= mem_addr;
          end else begin
            tail_data <= mem_rdata;
            tail_addr <= mem_addr;
          end
        end else if (pop) begin
          head_data <= tail_data;
          head_addr <= tail_addr;
        end
        count      <= count_after;
        inst_valid <= (count_after != 2'd0);
      end

      // Request sequencing
      case (state)
        S_IDLE: begin
          if (pc_cmd) begin
            // The queue is flushed, so the target can be requested at once.
            state      <= S_REQ;
            mem_req    <= 1'b1;
            mem_addr   <= pc_datain;
            pc_dataout <= pc_datain;
          end else if (count < 2'd2) begin
            state    <= S_REQ;
            mem_req  <= 1'b1;
            mem_addr <= pc_dataout;
          end
        end

        S_REQ: begin
          if (pc_cmd) begin
            pc_dataout <= pc_datain;
            if (mem_ack) begin
              // Bus is free this cycle: discard the word, start the target.
              mem_addr <= pc_datain;
            end else begin
              // Request must stay stable until the memory answers.
              state <= S_DROP;
            end
          end else if (mem_ack) begin
            pc_dataout <= pc_next;
            if (count_after < 2'd2) begin
              mem_addr <= pc_next;
            end else begin
              state   <= S_IDLE;
              mem_req <= 1'b0;
            end
          end
        end

        S_DROP: begin
          if (pc_cmd)
            pc_dataout <= pc_datain;
          if (mem_ack) begin
            state    <= S_REQ;
            mem_addr <= pc_cmd ? pc_datain : pc_dataout;
          end
        end

        default: begin
          state   <= S_IDLE;
          mem_req <= 1'b0;
        end
      endcase
    end
  end

`ifdef IFETCH_PERF_EN
  always_ff @(posedge clock) begin
    if (!reset_) begin
      perf_fetch <= 16'd0;
      perf_drop  <= 16'd0;
    end else begin
      if (push && perf_fetch != 16'hFFFF)
        perf_fetch <= perf_fetch + 16'd1;
      if (drop_ack && perf_drop != 16'hFFFF)
        perf_drop <= perf_drop + 16'd1;
    end
  end
`else
  // Without the counters the drop indication has no consumer.
  logic unused_drop;
  assign unused_drop = drop_ack;
`endif

endmodule

// File: doc/ifetch.md
IFETCH -- requirements
Module: ifetch

Interface
REQ-001 SHALL have port: clock  in  1  rising-edge clock for all state.
REQ-002 SHALL have port: reset_  in  1  synchronous active-low reset, sampled on rising clock.
REQ-003 SHALL have port: mem_req  out  1  instruction-memory read request.
REQ-004 SHALL have port: mem_addr  out  12  word address of the request.
REQ-005 SHALL have port: mem_ack  in  1  read data valid / request accepted, this cycle.
REQ-006 SHALL have port: mem_rdata  in  32  read data, valid when mem_ack=1.
REQ-007 SHALL have port: pc_cmd  in  1  redirect fetch stream (branch taken).
REQ-008 SHALL have port: pc_datain  in  12  redirect target.
REQ-009 SHALL have port: ir_cmd  in  1  consumer takes head instruction.
REQ-010 SHALL have port: inst_valid  out  1  head instruction available.
REQ-011 SHALL have ports: op out 4 = head[31:28]; cc out 4 = head[27:24]; s_a out 12 = head[23:12]; de_a out 12 = head[11:0].
REQ-012 SHALL have port: inst_pc  out  12  address of head instruction.
REQ-013 SHALL have port: pc_dataout  out  12  next fetch address (fetch PC).

Function
REQ-014 SHALL buffer fetched words with their addresses in a 2-entry FIFO; occupancy 0..2.
REQ-015 SHALL run FSM states IDLE, REQ, DROP.
REQ-016 IDLE -> REQ when occupancy + outstanding < 2 and no redirect this cycle; mem_req=1, mem_addr=pc_dataout from the next cycle.
REQ-017 In REQ, mem_req and mem_addr SHALL stay constant until mem_ack=1; mem_ack=0 for any number of cycles is legal.
REQ-018 On mem_ack in REQ without redirect: push {mem_rdata, mem_addr}; pc_dataout += 1, wrapping 0xFFF -> 0x000; go to REQ again if space remains after push/pop, else IDLE.
REQ-019 Pop when ir_cmd=1 and inst_valid=1; ir_cmd with empty FIFO SHALL be ignored.
REQ-020 Push and pop in the same cycle SHALL leave occupancy unchanged and keep order.
REQ-021 Push at occupancy 2 SHALL never occur.
REQ-022 On pc_cmd=1: flush FIFO (inst_valid=0 next cycle); pc_dataout <= pc_datain; ir_cmd the same cycle ignored.
REQ-023 pc_cmd in REQ with mem_ack=0 -> DROP: mem_req held at old address until mem_ack, data discarded, then REQ at new pc_dataout.
REQ-024 pc_cmd with mem_ack=1 in the same cycle SHALL discard that data and not increment past the target.
REQ-025 pc_cmd in DROP SHALL update pc_dataout only; remain in DROP.
REQ-026 Latency: pc_cmd at cycle N, zero-wait memory -> mem_req with target at N+1, inst_valid=1 at N+2.
REQ-027 inst_valid, op, cc, s_a, de_a, inst_pc SHALL be registered FIFO-head values; no combinational path from mem_rdata.

Reset
REQ-028 reset_=0 at a rising edge SHALL force: state IDLE, occupancy 0, inst_valid 0, mem_req 0, mem_addr 0, pc_dataout 0, inst_pc 0, op/cc/s_a/de_a 0; overrides pc_cmd/ir_cmd/mem_ack.
REQ-029 Reset during an outstanding request SHALL drop it; a mem_ack arriving after reset with mem_req=0 SHALL be ignored.

Configuration
REQ-030 With IFETCH_PERF_EN defined: add outputs perf_fetch out 16 (pushes) and perf_drop out 16 (discarded acks), each saturating at 0xFFFF, reset to 0.
REQ-031 Without IFETCH_PERF_EN: ports and counters absent; all other behaviour identical.

Verification
REQ-032 Reset, mem_ack tied 1, mem_rdata=0x2A00_5007 -> mem_addr 0x000 then 0x001; inst_valid at cycle 2; op=2, cc=A, s_a=0x005, de_a=0x007, inst_pc=0x000.
REQ-033 ir_cmd=0, ack always 1 -> exactly 2 pushes, mem_req=0 after 2nd ack, occupancy 2; one ir_cmd -> one new request, addr 0x002.
REQ-034 Request at 0x010 with 3 wait cycles, pc_cmd target 0x100 in wait cycle 1 -> mem_addr holds 0x010 until ack, data discarded (perf_drop=1), next mem_addr 0x100.
REQ-035 pc_dataout=0xFFF, ack -> pushed inst_pc=0xFFF, pc_dataout=0x000.
REQ-036 pc_cmd and mem_ack and ir_cmd same cycle at occupancy 1 -> FIFO empty next cycle, pc_dataout=target, no push.
REQ-037 reset_=0 for one cycle while mem_req=1 -> all outputs at reset values next cycle; fetch restarts at 0x000.
